glyph_plotter: RTL and testbench
================================

GLYPH_PLOTTER -- requirements
Module: glyph_plotter

Interface
REQ-001 The block SHALL have parameter CHAR_W, default 8, meaning glyph cell width in pixels.
REQ-002 The block SHALL have parameter CHAR_H, default 16, meaning glyph cell height in pixels.
REQ-003 The block SHALL have parameter COLS, default 40, meaning text columns (320 px / 8).
REQ-004 The block SHALL have parameter ROWS, default 15, meaning text rows (240 px / 16).
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port RESETN, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port REQ_VALID, input, 1 bit: a draw request is present.
REQ-008 The block SHALL have port REQ_READY, output, 1 bit: the block can accept a request.
REQ-009 The block SHALL have port REQ_CHAR, input, 7 bits: ASCII code to draw.
REQ-010 The block SHALL have port REQ_COL, input, 6 bits: target text column.
REQ-011 The block SHALL have port REQ_ROW, input, 4 bits: target text row.
REQ-012 The block SHALL have ports FG_COLOUR and BG_COLOUR, input, 3 bits each: colours for set and clear glyph bits.
REQ-013 The block SHALL have ports X (output, 9 bits) and Y (output, 8 bits): pixel coordinate.
REQ-014 The block SHALL have port COLOUR, output, 3 bits: pixel colour.
REQ-015 The block SHALL have port PLOT, output, 1 bit: pixel write valid.
REQ-016 The block SHALL have port PIX_READY, input, 1 bit: the pixel sink accepts a write.
REQ-017 The block SHALL have port DONE, output, 1 bit: one-cycle pulse marking request completion.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, DRAW and FINISH; REQ_READY SHALL be 1 only in IDLE.
REQ-019 In IDLE, REQ_VALID&REQ_READY SHALL capture REQ_CHAR, REQ_COL, REQ_ROW, FG_COLOUR and BG_COLOUR, then go to LOAD.
REQ-020 In LOAD, the 128-bit glyph for the captured code SHALL be registered: row 0 = bits 127:120, pixel column 0 = MSB of each row. Next state SHALL be DRAW with pixel counter p=0, or FINISH if col>=COLS or row>=ROWS.
REQ-021 In DRAW, PLOT SHALL be 1, with X=col*8+p[2:0], Y=row*16+p[6:3], and COLOUR=FG if glyph[127-p] else BG.
REQ-022 A pixel transfer SHALL occur on PLOT&PIX_READY; p SHALL advance only on a transfer, and X, Y and COLOUR SHALL hold stable while stalled.
REQ-023 The transfer at p=127 SHALL move the FSM to FINISH. FINISH SHALL assert DONE for exactly one cycle, then return to IDLE.
REQ-024 X, Y, COLOUR, PLOT, DONE and REQ_READY SHALL be decoded from registered state only, with no combinational path from any input.
REQ-025 With PIX_READY held at 1: first PLOT in the 2nd cycle after the accept edge; 128 consecutive PLOT cycles; DONE in the cycle after the last PLOT; REQ_READY in the cycle after DONE.
REQ-026 Codes with a blank glyph (0-31, 127, 32) SHALL still draw the full cell in BG colour.
REQ-027 REQ_VALID SHALL be ignored outside IDLE, and captured values SHALL not change mid-request.
REQ-028 X and Y arithmetic SHALL be unsigned, computed without truncation in 9 and 8 bits respectively.

Reset
REQ-029 RESETN=0 SHALL immediately force: state IDLE, p=0, glyph=0, captured registers=0, PLOT=0, DONE=0, X=0, Y=0, COLOUR=0, REQ_READY=1.
REQ-030 Reset during DRAW SHALL abandon the request without a DONE pulse.

Structure
REQ-031 CHAR_W, CHAR_H, COLS, ROWS, the coordinate widths and the state encodings SHALL live in a shared package, plotter_defs.
REQ-032 The block SHALL instantiate exactly one sub-module, char_decoder (7-bit code in, 128-bit glyph out, combinational), fed from the captured code.

Verification
REQ-033 Reset; 'A'(65) at col 0, row 0, FG=111, BG=000, PIX_READY=1 -> 128 PLOTs raster order X 0..7, Y 0..15; (3,1)=111; (0,0)=000; DONE once.
REQ-034 'H'(72) at col 39, row 14 -> X spans 312..319, Y spans 224..239; (1,1)=FG; (0,1)=BG.
REQ-035 PIX_READY alternating 1/0 -> exactly 128 transfers; X, Y and COLOUR unchanged across each stall; DONE after the 128th transfer.
REQ-036 REQ_COL=40 (or REQ_ROW=15) -> no PLOT; DONE in the 2nd cycle after accept.
REQ-037 RESETN pulsed low at p=60 -> PLOT=0 and DONE=0 immediately; REQ_READY=1 after release; next request draws all 128 pixels.
REQ-038 REQ_VALID held with a different REQ_CHAR during DRAW -> ignored; single DONE; pixels match the first code only.

Source files
------------

// File: rtl/glyph_plotter_pkg.sv
// Shared constants, state encoding and character helpers for the glyph plotter.
package plotter_defs;

  localparam int DEF_CHAR_W = 8;
  localparam int DEF_CHAR_H = 16;
  localparam int DEF_COLS   = 40;
  localparam int DEF_ROWS   = 15;

  localparam int X_W        = 9;
  localparam int Y_W        = 8;
  localparam int CODE_W     = 7;
  localparam int COL_W      = 6;
  localparam int ROW_W      = 4;
  localparam int COLOUR_W   = 3;
  localparam int GLYPH_BITS = DEF_CHAR_W * DEF_CHAR_H;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Lower-case letters share the upper-case artwork.
  function automatic logic [CODE_W-1:0] fold_case(input logic [CODE_W-1:0] code);
    if ((code >= 7'd97) && (code <= 7'd122)) begin
      return code - 7'd32;
    end else begin
      return code;
    end
  endfunction

  function automatic logic is_printable(input logic [CODE_W-1:0] code);
    return (code >= 7'd33) && (code <= 7'd126);
  endfunction

endpackage

// File: rtl/glyph_plotter_char_decoder.sv
// Combinational 8x16 font ROM: 8x8 artwork with every row doubled vertically.
// Letters and digits have artwork; other printable codes show a hollow box.
module char_decoder
  import plotter_defs::*;
(
  input  logic [CODE_W-1:0]     code,
  output logic [GLYPH_BITS-1:0] glyph
);

  logic [CODE_W-1:0] key_s;
  logic [63:0]       base_s;

  // Look up the 8x8 artwork, row 0 in the top byte, leftmost pixel in the MSB.
  always_comb begin
    key_s = fold_case(code);
    case (key_s)
      7'h30:   base_s = 64'h3C666E7666663C00;
      7'h31:   base_s = 64'h1838181818187E00;
      7'h32:   base_s = 64'h3C66060C30607E00;
      7'h33:   base_s = 64'h3C66061C06663C00;
      7'h34:   base_s = 64'h0C1C3C6C7E0C0C00;
      7'h35:   base_s = 64'h7E607C0606663C00;
      7'h36:   base_s = 64'h3C66607C66663C00;
      7'h37:   base_s = 64'h7E660C1818181800;
      7'h38:   base_s = 64'h3C66663C66663C00;
      7'h39:   base_s = 64'h3C66663E06663C00;
      7'h41:   base_s = 64'h183C66667E666600;
      7'h42:   base_s = 64'h7C66667C66667C00;
      7'h43:   base_s = 64'h3C66606060663C00;
      7'h44:   base_s = 64'h786C6666666C7800;
      7'h45:   base_s = 64'h7E60607C60607E00;
      7'h46:   base_s = 64'h7E60607C60606000;
      7'h47:   base_s = 64'h3C66606E66663C00;
      7'h48:   base_s = 64'h6666667E66666600;
      7'h49:   base_s = 64'h3C18181818183C00;
      7'h4A:   base_s = 64'h1E0C0C0C0C6C3800;
      7'h4B:   base_s = 64'h666C7870786C6600;
      7'h4C:   base_s = 64'h6060606060607E00;
      7'h4D:   base_s = 64'h63777F6B63636300;
      7'h4E:   base_s = 64'h66767E7E6E666600;
      7'h4F:   base_s = 64'h3C66666666663C00;
      7'h50:   base_s = 64'h7C66667C60606000;
      7'h51:   base_s = 64'h3C666666663C0E00;
      7'h52:   base_s = 64'h7C66667C786C6600;
      7'h53:   base_s = 64'h3C66603C06663C00;
      7'h54:   base_s = 64'h7E18181818181800;
      7'h55:   base_s = 64'h6666666666663C00;
      7'h56:   base_s = 64'h66666666663C1800;
      7'h57:   base_s = 64'h6363636B7F776300;
      7'h58:   base_s = 64'h66663C183C666600;
      7'h59:   base_s = 64'h6666663C18181800;
      7'h5A:   base_s = 64'h7E060C1830607E00;
      default: base_s = is_printable(key_s) ? 64'hFF818181818181FF : 64'h0;
    endcase
  end

  // Stretch each artwork row over two glyph rows.
  always_comb begin
    glyph = '0;
    for (int r = 0; r < 8; r++) begin
      glyph[GLYPH_BITS-1-16*r -: 8] = base_s[63-8*r -: 8];
      glyph[GLYPH_BITS-9-16*r -: 8] = base_s[63-8*r -: 8];
    end
  end

endmodule

// File: rtl/glyph_plotter.sv
// Draws one text glyph cell per request as a stream of pixel writes.
// All outputs are flops loaded from next-state values, so no input reaches an output combinationally.
module glyph_plotter
  import plotter_defs::*;
#(
  parameter int CHAR_W = DEF_CHAR_W,
  parameter int CHAR_H = DEF_CHAR_H,
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic [CODE_W-1:0]   REQ_CHAR,
  input  logic [COL_W-1:0]    REQ_COL,
  input  logic [ROW_W-1:0]    REQ_ROW,
  input  logic [COLOUR_W-1:0] FG_COLOUR,
  input  logic [COLOUR_W-1:0] BG_COLOUR,
  output logic [X_W-1:0]      X,
  output logic [Y_W-1:0]      Y,
  output logic [COLOUR_W-1:0] COLOUR,
  output logic                PLOT,
  input  logic                PIX_READY,
  output logic                DONE
);

  localparam int                PX_W      = $clog2(CHAR_W);
  localparam int                P_W       = $clog2(CHAR_W * CHAR_H);
  localparam logic [P_W-1:0]    P_LAST    = P_W'(CHAR_W * CHAR_H - 1);
  localparam logic [COL_W-1:0]  COL_LIMIT = COL_W'(COLS);
  localparam logic [ROW_W-1:0]  ROW_LIMIT = ROW_W'(ROWS);

  state_e                state_q, state_d;
  logic [P_W-1:0]        p_q, p_d;
  logic [GLYPH_BITS-1:0] glyph_q, glyph_d, glyph_s;
  logic [CODE_W-1:0]     char_q, char_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COLOUR_W-1:0]   fg_q, fg_d, bg_q, bg_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic                  plot_q, plot_d, done_q, done_d, ready_q, ready_d;

  char_decoder u_dec (
    .code  (char_q),
    .glyph (glyph_s)
  );

  // Request sequencing: capture, glyph load, pixel walk, completion pulse.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    glyph_d = glyph_q;
    char_d  = char_q;
    col_d   = col_q;
    row_d   = row_q;
    fg_d    = fg_q;
    bg_d    = bg_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID && ready_q) begin
          char_d  = REQ_CHAR;
          col_d   = REQ_COL;
          row_d   = REQ_ROW;
          fg_d    = FG_COLOUR;
          bg_d    = BG_COLOUR;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        glyph_d = glyph_s;
        p_d     = '0;
        if ((col_q >= COL_LIMIT) || (row_q >= ROW_LIMIT)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (plot_q && PIX_READY) begin
          if (p_q == P_LAST) begin
            state_d = ST_FINISH;
          end else begin
            p_d = p_q + P_W'(1);
          end
        end else begin
          p_d = p_q;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so they hold while stalled.
  always_comb begin
    plot_d   = (state_d == ST_DRAW);
    done_d   = (state_d == ST_FINISH);
    ready_d  = (state_d == ST_IDLE);
    if (state_d == ST_DRAW) begin
      x_d      = X_W'(col_d) * X_W'(CHAR_W) + X_W'(p_d[PX_W-1:0]);
      y_d      = Y_W'(row_d) * Y_W'(CHAR_H) + Y_W'(p_d[P_W-1:PX_W]);
      colour_d = glyph_d[P_LAST - p_d] ? fg_d : bg_d;
    end else begin
      x_d      = '0;
      y_d      = '0;
      colour_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      glyph_q  <= '0;
      char_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      glyph_q  <= glyph_d;
      char_q   <= char_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign X         = x_q;
  assign Y         = y_q;
  assign COLOUR    = colour_q;
  assign PLOT      = plot_q;
  assign DONE      = done_q;
  assign REQ_READY = ready_q;

endmodule

// File: tb/tb_glyph_plotter.sv
// Scoreboard bench for glyph_plotter: a pixel-art font model predicts every write,
// a negedge monitor pops and compares each transfer and DONE pulse.
module tb_glyph_plotter;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [6:0] REQ_CHAR = 7'd0;
  logic [5:0] REQ_COL = 6'd0;
  logic [3:0] REQ_ROW = 4'd0;
  logic [2:0] FG_COLOUR = 3'd0;
  logic [2:0] BG_COLOUR = 3'd0;
  logic [8:0] X;
  logic [7:0] Y;
  logic [2:0] COLOUR;
  logic       PLOT;
  logic       PIX_READY = 1'b1;
  logic       DONE;

  always #5 CLK = ~CLK;

  glyph_plotter dut (
    .CLK(CLK), .RESETN(RESETN), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_CHAR(REQ_CHAR), .REQ_COL(REQ_COL), .REQ_ROW(REQ_ROW),
    .FG_COLOUR(FG_COLOUR), .BG_COLOUR(BG_COLOUR), .X(X), .Y(Y),
    .COLOUR(COLOUR), .PLOT(PLOT), .PIX_READY(PIX_READY), .DONE(DONE)
  );

  typedef struct { int x; int y; int c; } pix_t;

  int   checks = 0, errors = 0;
  int   cyc = 0;
  pix_t exp_q[$];
  int   exp_done = 0, done_cnt = 0, xfer_cnt = 0;
  int   first_plot_cyc = -1, last_xfer_cyc = -1, done_cyc = -1, acc_cyc = -1;
  int   pr_mode = 0;
  logic [2:0] pix_mem [int];

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Font artwork: 8 rows of 8 pixels, each row covering two pixel lines of the cell.
  function automatic string art_row(int ch, int r);
    string a [8];
    int k;
    k = (ch >= 97 && ch <= 122) ? ch - 32 : ch;
    case (k)
      65: a = '{"...##...", "..####..", ".##..##.", ".##..##.", ".######.", ".##..##.", ".##..##.", "........"};
      72: a = '{".##..##.", ".##..##.", ".##..##.", ".######.", ".##..##.", ".##..##.", ".##..##.", "........"};
      84: a = '{".######.", "...##...", "...##...", "...##...", "...##...", "...##...", "...##...", "........"};
      48: a = '{"..####..", ".##..##.", ".##.###.", ".###.##.", ".##..##.", ".##..##.", "..####..", "........"};
      default: begin
        if (k >= 33 && k <= 126)
          a = '{"########", "#......#", "#......#", "#......#", "#......#", "#......#", "#......#", "########"};
        else
          a = '{default: "........"};
      end
    endcase
    return a[r];
  endfunction

  function automatic bit lit(int ch, int px, int py);
    string s;
    s = art_row(ch, py / 2);
    return s[px] == "#";
  endfunction

  task automatic push_expect(int ch, int col, int row, int fg, int bg);
    if (col < 40 && row < 15) begin
      for (int p = 0; p < 128; p++) begin
        pix_t e;
        e.x = col * 8 + p % 8;
        e.y = row * 16 + p / 8;
        e.c = lit(ch, p % 8, p / 8) ? fg : bg;
        exp_q.push_back(e);
      end
    end
    exp_done++;
  endtask

  // PIX_READY pattern generator: steady, alternating or random.
  initial forever begin
    @(posedge CLK); #1;
    case (pr_mode)
      0:       PIX_READY = 1'b1;
      1:       PIX_READY = ~PIX_READY;
      default: PIX_READY = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare each transfer and DONE pulse against the scoreboard.
  initial begin
    logic       stall_prev;
    logic [8:0] px_prev;
    logic [7:0] py_prev;
    logic [2:0] pc_prev;
    stall_prev = 1'b0;
    px_prev = '0; py_prev = '0; pc_prev = '0;
    forever begin
      @(negedge CLK);
      if (RESETN) begin
        if (stall_prev) begin
          chk("stall_plot", int'(PLOT), 1);
          chk("stall_x", int'(X), int'(px_prev));
          chk("stall_y", int'(Y), int'(py_prev));
          chk("stall_colour", int'(COLOUR), int'(pc_prev));
        end
        stall_prev = PLOT && !PIX_READY;
        px_prev = X; py_prev = Y; pc_prev = COLOUR;
        if (REQ_VALID && REQ_READY) acc_cyc = cyc;
        if (PLOT && first_plot_cyc < 0) first_plot_cyc = cyc;
        if (PLOT && PIX_READY) begin
          xfer_cnt++;
          last_xfer_cyc = cyc;
          pix_mem[int'(Y) * 512 + int'(X)] = COLOUR;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_plot: got write at x=%0d y=%0d, expected none", X, Y);
          end else begin
            pix_t e;
            e = exp_q.pop_front();
            chk("pix_x", int'(X), e.x);
            chk("pix_y", int'(Y), e.y);
            chk("pix_colour", int'(COLOUR), e.c);
          end
        end
        if (DONE) begin
          done_cnt++;
          done_cyc = cyc;
          checks++;
          if (exp_done == 0) begin
            errors++;
            $display("FAIL unexpected_done: got DONE=1, expected 0 (t=%0t)", $time);
          end else begin
            exp_done--;
          end
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int to;
    to = 0;
    do begin
      @(posedge CLK); #1;
      to++;
    end while (!REQ_READY && to < 50);
    if (!REQ_READY) chk("ready_timeout", int'(REQ_READY), 1);
  endtask

  task automatic issue(int ch, int col, int row, int fg, int bg);
    wait_ready();
    xfer_cnt = 0; first_plot_cyc = -1; last_xfer_cyc = -1;
    pix_mem.delete();
    push_expect(ch, col, row, fg, bg);
    REQ_VALID = 1'b1;
    REQ_CHAR  = 7'(ch);
    REQ_COL   = 6'(col);
    REQ_ROW   = 4'(row);
    FG_COLOUR = 3'(fg);
    BG_COLOUR = 3'(bg);
    @(posedge CLK); #1;
  endtask

  task automatic run_req(int ch, int col, int row, int fg, int bg, int mode, bit hold_other);
    int d0, to, exp_n;
    exp_n = (col < 40 && row < 15) ? 128 : 0;
    pr_mode = mode;
    d0 = done_cnt;
    issue(ch, col, row, fg, bg);
    if (hold_other) begin
      REQ_CHAR  = (ch == 65) ? 7'd72 : 7'd65;
      REQ_COL   = 6'(col + 1);
      FG_COLOUR = ~3'(fg);
    end else begin
      REQ_VALID = 1'b0;
    end
    to = 0;
    while (done_cnt == d0 && to < 3000) begin
      @(posedge CLK); #1;
      to++;
      if (hold_other && xfer_cnt >= 100) REQ_VALID = 1'b0;
    end
    REQ_VALID = 1'b0;
    if (done_cnt == d0) begin
      chk("done_timeout", done_cnt - d0, 1);
    end else begin
      chk("ready_after_done", int'(REQ_READY), 1);
      chk("done_one_cycle", int'(DONE), 0);
      chk("xfer_count", xfer_cnt, exp_n);
      chk("pix_left", exp_q.size(), 0);
      if (exp_n == 0) begin
        chk("done_latency_oob", done_cyc - acc_cyc, 2);
      end else begin
        chk("done_after_last", done_cyc - last_xfer_cyc, 1);
        if (mode == 0) begin
          chk("first_plot_latency", first_plot_cyc - acc_cyc, 2);
          chk("plot_span", last_xfer_cyc - first_plot_cyc, 127);
        end
      end
    end
  endtask

  task automatic check_px(string name, int x, int y, int exp);
    if (!pix_mem.exists(y * 512 + x)) begin
      checks++; errors++;
      $display("FAIL %s: got no write at (%0d,%0d), expected colour %0d", name, x, y, exp);
    end else begin
      chk(name, int'(pix_mem[y * 512 + x]), exp);
    end
  endtask

  initial begin
    int chars [9] = '{65, 72, 84, 48, 97, 32, 0, 127, 126};
    int to, d0;

    #12;
    chk("rst_ready", int'(REQ_READY), 1);
    chk("rst_plot", int'(PLOT), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_x", int'(X), 0);
    chk("rst_y", int'(Y), 0);
    chk("rst_colour", int'(COLOUR), 0);
    #10 RESETN = 1'b1;

    run_req(65, 0, 0, 7, 0, 0, 1'b0);
    check_px("a_px_3_1", 3, 1, 7);
    check_px("a_px_0_0", 0, 0, 0);

    run_req(72, 39, 14, 5, 2, 0, 1'b0);
    check_px("h_px_1_1", 313, 225, 5);
    check_px("h_px_0_1", 312, 225, 2);
    check_px("h_corner", 319, 239, 2);

    run_req(84, 10, 5, 6, 1, 1, 1'b0);
    run_req(65, 40, 0, 7, 0, 0, 1'b0);
    run_req(65, 0, 15, 7, 0, 0, 1'b0);

    // Reset in the middle of a draw abandons it without DONE.
    pr_mode = 0;
    d0 = done_cnt;
    issue(65, 5, 3, 4, 3);
    REQ_VALID = 1'b0;
    to = 0;
    while (xfer_cnt < 60 && to < 500) begin
      @(posedge CLK); #1;
      to++;
    end
    chk("rst_at_p60", xfer_cnt, 60);
    RESETN = 1'b0;
    #1;
    chk("midrst_plot", int'(PLOT), 0);
    chk("midrst_done", int'(DONE), 0);
    chk("midrst_ready", int'(REQ_READY), 1);
    chk("midrst_x", int'(X), 0);
    chk("midrst_y", int'(Y), 0);
    exp_q.delete();
    exp_done = 0;
    @(posedge CLK); #2;
    RESETN = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("midrst_ready_after", int'(REQ_READY), 1);
    chk("midrst_no_done", done_cnt - d0, 0);
    run_req(65, 5, 3, 4, 3, 0, 1'b0);

    d0 = done_cnt;
    run_req(65, 2, 2, 3, 4, 0, 1'b1);
    repeat (6) @(posedge CLK);
    #1;
    chk("hold_single_done", done_cnt - d0, 1);

    run_req(32, 7, 7, 1, 6, 2, 1'b0);
    run_req(0, 8, 1, 2, 5, 0, 1'b0);
    run_req(127, 9, 2, 3, 4, 1, 1'b0);
    run_req(97, 11, 3, 7, 1, 0, 1'b0);
    run_req(126, 12, 4, 6, 2, 2, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_req(chars[$urandom_range(0, 8)], int'($urandom_range(0, 42)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
